// File: rtl/alu_req_parser.sv
// Byte-stream parser that assembles 9-byte ALU request packets (command, operand A, operand B)
// and holds each request until the ALU accepts it; stalled partial packets are dropped on timeout.
module alu_req_parser #(
    parameter logic [31:0] TimeoutCycles = 32'd1000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [1:0]  opcode_o,
    output logic [31:0] operand_a_o,
    output logic [31:0] operand_b_o,
    input  logic        ready_i,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPA  = 2'd1,
        ST_OPB  = 2'd2,
        ST_SEND = 2'd3
    } state_t;

    localparam logic        TimeoutEn   = (TimeoutCycles != 32'd0);
    localparam logic [31:0] TimeoutLast = TimeoutCycles - 32'd1;

    function automatic logic [1:0] decode_cmd(input logic [7:0] cmd);
        logic [1:0] op;
        case (cmd)
            8'h01:   op = 2'd1;
            8'h02:   op = 2'd2;
            8'h03:   op = 2'd3;
            default: op = 2'd0;
        endcase
        return op;
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [1:0]  opc_q, opc_d;
    logic        tmo_pulse_q, tmo_pulse_d;

    logic ready_s;
    logic valid_s;
    logic byte_xfer_s;
    logic req_xfer_s;
    logic in_operand_s;
    logic timeout_hit_s;

    assign byte_xfer_s  = valid_i & ready_s;
    assign req_xfer_s   = valid_s & ready_i;
    assign in_operand_s = (state_q == ST_OPA) || (state_q == ST_OPB);
    // The counter trips on the edge where it would reach TimeoutCycles; a byte arriving then wins.
    assign timeout_hit_s = TimeoutEn && in_operand_s && !byte_xfer_s && (tmo_cnt_q == TimeoutLast);

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (byte_xfer_s) begin
                    state_d = ST_OPA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OPA: begin
                if (byte_xfer_s && (idx_q == 2'd3)) begin
                    state_d = ST_OPB;
                end else if (timeout_hit_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OPA;
                end
            end
            ST_OPB: begin
                if (byte_xfer_s && (idx_q == 2'd3)) begin
                    state_d = ST_SEND;
                end else if (timeout_hit_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OPB;
                end
            end
            ST_SEND: begin
                if (req_xfer_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        ready_s = 1'b1;
        valid_s = 1'b0;
        if (state_q == ST_SEND) begin
            ready_s = 1'b0;
            valid_s = 1'b1;
        end else begin
            ready_s = 1'b1;
            valid_s = 1'b0;
        end
    end

    // Datapath next-state: byte index, idle counter, operand capture, timeout pulse
    always_comb begin
        idx_d       = idx_q;
        tmo_cnt_d   = tmo_cnt_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        opc_d       = opc_q;
        tmo_pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idx_d     = 2'd0;
                tmo_cnt_d = 32'd0;
                if (byte_xfer_s) begin
                    opc_d = decode_cmd(data_i);
                end else begin
                    opc_d = opc_q;
                end
            end
            ST_OPA, ST_OPB: begin
                if (byte_xfer_s) begin
                    if (state_q == ST_OPA) begin
                        opa_d[{idx_q, 3'b000} +: 8] = data_i;
                    end else begin
                        opb_d[{idx_q, 3'b000} +: 8] = data_i;
                    end
                    idx_d     = idx_q + 2'd1;
                    tmo_cnt_d = 32'd0;
                end else if (timeout_hit_s) begin
                    idx_d       = 2'd0;
                    tmo_cnt_d   = 32'd0;
                    tmo_pulse_d = 1'b1;
                end else if (TimeoutEn) begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q;
                end
            end
            ST_SEND: begin
                idx_d     = 2'd0;
                tmo_cnt_d = 32'd0;
            end
            default: begin
                idx_d     = 2'd0;
                tmo_cnt_d = 32'd0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            idx_q       <= 2'd0;
            tmo_cnt_q   <= 32'd0;
            opa_q       <= 32'd0;
            opb_q       <= 32'd0;
            opc_q       <= 2'd0;
            tmo_pulse_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            tmo_cnt_q   <= tmo_cnt_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            opc_q       <= opc_d;
            tmo_pulse_q <= tmo_pulse_d;
        end
    end

    assign ready_o     = ready_s;
    assign valid_o     = valid_s;
    assign opcode_o    = opc_q;
    assign operand_a_o = opa_q;
    assign operand_b_o = opb_q;
    assign timeout_o   = tmo_pulse_q;

endmodule

// File: tb/tb_alu_req_parser.sv
// Scoreboard bench for alu_req_parser: expected requests are queued when packets are driven
// and checked when the parser presents them.
module tb_alu_req_parser;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        ready_o;
    logic        valid_o;
    logic [1:0]  opcode_o;
    logic [31:0] operand_a_o;
    logic [31:0] operand_b_o;
    logic        ready_i;
    logic        timeout_o;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   req_cnt = 0;
    int   tmo_cnt = 0;

    alu_req_parser #(.TimeoutCycles(32'd8)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .opcode_o    (opcode_o),
        .operand_a_o (operand_a_o),
        .operand_b_o (operand_b_o),
        .ready_i     (ready_i),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (valid_o && ready_i) req_cnt <= req_cnt + 1;
        if (timeout_o) tmo_cnt <= tmo_cnt + 1;
    end

    function automatic logic [1:0] model_op(input logic [7:0] cmd);
        if (cmd == 8'h01) return 2'd1;
        if (cmd == 8'h02) return 2'd2;
        if (cmd == 8'h03) return 2'd3;
        return 2'd0;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        data_i = b;
        valid_i = 1'b1;
        while (!acc && n < 50) begin
            acc = ready_o;
            step();
            n++;
        end
        valid_i = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL byte_accept: byte %h not accepted within 50 cycles", b);
        end
    endtask

    task automatic send_packet(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.op = model_op(cmd);
        e.a = a;
        e.b = b;
        exp_q.push_back(e);
        send_byte(cmd);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8]);
    endtask

    task automatic wait_valid(output bit seen);
        int n;
        n = 0;
        seen = valid_o;
        while (!seen && n < 40) begin
            step();
            n++;
            seen = valid_o;
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        valid_i = 1'b0;
        data_i = 8'h00;
        ready_i = 1'b0;
        step();
        step();
        n_cmp++;
        if ({ready_o, valid_o, timeout_o} !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_hs: got rdy/vld/tmo=%b required 100", {ready_o, valid_o, timeout_o});
        end
        n_cmp++;
        if ({opcode_o, operand_a_o, operand_b_o} !== 66'd0) begin
            n_bad++;
            $display("FAIL reset_data: got op=%0d a=%h b=%h required zeros", opcode_o, operand_a_o, operand_b_o);
        end
        reset_i = 1'b0;
        step();
        n_cmp++;
        if (ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b required 1", ready_o);
        end
    endtask

    task automatic test_add();
        bit   seen;
        exp_t e;
        int   r0;
        ready_i = 1'b1;
        r0 = req_cnt;
        send_packet(8'h01, 32'h12345678, 32'h00000001);
        seen = valid_o;
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL add_latency: valid_o got 0 required 1 one cycle after 9th byte");
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({opcode_o, operand_a_o, operand_b_o} !== {e.op, e.a, e.b}) begin
            n_bad++;
            $display("FAIL add_req: got op=%0d a=%h b=%h required op=%0d a=%h b=%h",
                     opcode_o, operand_a_o, operand_b_o, e.op, e.a, e.b);
        end
        step();
        n_cmp++;
        if ({valid_o, ready_o} !== 2'b01 || req_cnt != r0 + 1) begin
            n_bad++;
            $display("FAIL add_single: got vld/rdy=%b reqs=%0d required 01 reqs=%0d", {valid_o, ready_o}, req_cnt - r0, 1);
        end
    endtask

    task automatic test_nop();
        bit   seen;
        exp_t e;
        ready_i = 1'b1;
        send_packet(8'h7F, 32'hAABBCCDD, 32'h11223344);
        wait_valid(seen);
        e = exp_q.pop_front();
        n_cmp++;
        if (!seen || {opcode_o, operand_a_o, operand_b_o} !== {e.op, e.a, e.b}) begin
            n_bad++;
            $display("FAIL nop_req: got vld=%b op=%0d a=%h b=%h required op=%0d a=%h b=%h",
                     seen, opcode_o, operand_a_o, operand_b_o, e.op, e.a, e.b);
        end
        step();
    endtask

    task automatic test_stall();
        bit   seen;
        exp_t e;
        int   r0;
        int   t0;
        int   bad_cycles;
        ready_i = 1'b0;
        r0 = req_cnt;
        t0 = tmo_cnt;
        send_packet(8'h02, 32'hCAFEF00D, 32'h0BADBEEF);
        wait_valid(seen);
        e = exp_q.pop_front();
        data_i = 8'h01;
        valid_i = 1'b1;
        bad_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!valid_o || ready_o || {opcode_o, operand_a_o, operand_b_o} !== {e.op, e.a, e.b})
                bad_cycles++;
        end
        n_cmp++;
        if (!seen || bad_cycles != 0) begin
            n_bad++;
            $display("FAIL stall_hold: got seen=%b unstable_cycles=%0d required 1/0", seen, bad_cycles);
        end
        n_cmp++;
        if (tmo_cnt != t0 || req_cnt != r0) begin
            n_bad++;
            $display("FAIL stall_quiet: got timeouts=%0d reqs=%0d required 0/0", tmo_cnt - t0, req_cnt - r0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        step();
        n_cmp++;
        if ({valid_o, ready_o} !== 2'b01 || req_cnt != r0 + 1) begin
            n_bad++;
            $display("FAIL stall_release: got vld/rdy=%b reqs=%0d required 01 reqs=1", {valid_o, ready_o}, req_cnt - r0);
        end
    endtask

    task automatic test_timeout();
        bit   seen;
        exp_t e;
        int   early;
        int   t0;
        ready_i = 1'b1;
        send_byte(8'h03);
        send_byte(8'hEE);
        send_byte(8'hDD);
        early = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (timeout_o) early++;
        end
        step();
        n_cmp++;
        if (early != 0 || timeout_o !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_pulse: got early=%0d tmo=%b required 0/1 after 8 idle cycles", early, timeout_o);
        end
        n_cmp++;
        if ({ready_o, valid_o} !== 2'b10) begin
            n_bad++;
            $display("FAIL timeout_idle: got rdy/vld=%b required 10", {ready_o, valid_o});
        end
        step();
        n_cmp++;
        if (timeout_o !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_width: got %b required 0 on second cycle", timeout_o);
        end
        send_packet(8'h03, 32'h00000064, 32'h00000007);
        wait_valid(seen);
        e = exp_q.pop_front();
        n_cmp++;
        if (!seen || {opcode_o, operand_a_o, operand_b_o} !== {e.op, e.a, e.b}) begin
            n_bad++;
            $display("FAIL timeout_recover: got vld=%b op=%0d a=%h b=%h required op=%0d a=%h b=%h",
                     seen, opcode_o, operand_a_o, operand_b_o, e.op, e.a, e.b);
        end
        step();
        // Byte arriving on the very cycle the counter would expire is accepted
        t0 = tmo_cnt;
        e.op = 2'd1;
        e.a = 32'h89ABCDEF;
        e.b = 32'h01020304;
        exp_q.push_back(e);
        send_byte(8'h01);
        for (int i = 0; i < 7; i++) step();
        for (int i = 0; i < 4; i++) send_byte(e.a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(e.b[8*i +: 8]);
        wait_valid(seen);
        e = exp_q.pop_front();
        n_cmp++;
        if (!seen || tmo_cnt != t0 || {opcode_o, operand_a_o, operand_b_o} !== {e.op, e.a, e.b}) begin
            n_bad++;
            $display("FAIL timeout_edge: got vld=%b timeouts=%0d op=%0d a=%h b=%h required 1/0 op=%0d a=%h b=%h",
                     seen, tmo_cnt - t0, opcode_o, operand_a_o, operand_b_o, e.op, e.a, e.b);
        end
        step();
    endtask

    task automatic test_reset_mid();
        bit   seen;
        exp_t e;
        int   r0;
        ready_i = 1'b1;
        send_byte(8'h01);
        send_byte(8'h44);
        send_byte(8'h33);
        send_byte(8'h22);
        send_byte(8'h11);
        #2;
        reset_i = 1'b1;
        #1;
        n_cmp++;
        if ({ready_o, valid_o, opcode_o, operand_a_o} !== {1'b1, 1'b0, 2'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL reset_async: got rdy=%b vld=%b op=%0d a=%h required 1/0/0/0", ready_o, valid_o, opcode_o, operand_a_o);
        end
        step();
        reset_i = 1'b0;
        step();
        r0 = req_cnt;
        send_packet(8'h02, 32'h00000006, 32'h00000007);
        wait_valid(seen);
        e = exp_q.pop_front();
        n_cmp++;
        if (!seen || {opcode_o, operand_a_o, operand_b_o} !== {e.op, e.a, e.b}) begin
            n_bad++;
            $display("FAIL reset_mid_req: got vld=%b op=%0d a=%h b=%h required op=%0d a=%h b=%h",
                     seen, opcode_o, operand_a_o, operand_b_o, e.op, e.a, e.b);
        end
        step();
        n_cmp++;
        if (req_cnt != r0 + 1) begin
            n_bad++;
            $display("FAIL reset_mid_count: got %0d requests required 1", req_cnt - r0);
        end
    endtask

    task automatic test_back_to_back();
        int   t[2];
        int   got;
        int   bad_req;
        exp_t e;
        ready_i = 1'b1;
        got = 0;
        bad_req = 0;
        fork
            begin
                send_packet(8'h01, 32'h0000AAAA, 32'h0000BBBB);
                send_packet(8'h03, 32'hFFFFFFFF, 32'h80000000);
            end
            begin
                for (int n = 0; n < 60 && got < 2; n++) begin
                    step();
                    if (valid_o) begin
                        t[got] = cyc;
                        if (exp_q.size() == 0) begin
                            bad_req++;
                        end else begin
                            e = exp_q.pop_front();
                            if ({opcode_o, operand_a_o, operand_b_o} !== {e.op, e.a, e.b}) bad_req++;
                        end
                        got++;
                    end
                end
            end
        join
        n_cmp++;
        if (got != 2 || bad_req != 0) begin
            n_bad++;
            $display("FAIL b2b_reqs: got %0d requests with %0d wrong required 2 with 0 wrong", got, bad_req);
        end
        n_cmp++;
        if (got == 2 && (t[1] - t[0]) != 10) begin
            n_bad++;
            $display("FAIL b2b_period: got %0d cycles required 10", t[1] - t[0]);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_nop();
        test_stall();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
